// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared FSM encoding, default widths and zero-register index for regfile_mp.
package regfile_mp_pkg;
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_IDX = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for in-flight writes with same-cycle write bypass on lookup.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_run,
    input  logic                     i_rsv,
    input  logic [ADDR_W-1:0]        i_rsv_a,
    input  logic                     i_we0,
    input  logic [ADDR_W-1:0]        i_wa0,
    input  logic                     i_we1,
    input  logic [ADDR_W-1:0]        i_wa1,
    input  logic [NUM_RD*ADDR_W-1:0] i_ra,
    output logic [NUM_RD-1:0]        o_rbusy
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DEPTH-1:0] r_busy, w_busy_nxt;
    // set is applied last so a newer reservation beats a same-cycle completing write
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_we0) w_busy_nxt[i_wa0] = 1'b0;
        if (i_we1) w_busy_nxt[i_wa1] = 1'b0;
        if (i_rsv) w_busy_nxt[i_rsv_a] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_busy <= '0;
        else r_busy <= w_busy_nxt;
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rb
        logic [ADDR_W-1:0] w_a;
        assign w_a = i_ra[k*ADDR_W +: ADDR_W];
        assign o_rbusy[k] = i_run && r_busy[w_a] && !(i_we0 && i_wa0 == w_a) && !(i_we1 && i_wa1 == w_a);
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports, write-to-read bypass,
// busy scoreboard and a sequential clear sweep after reset.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_a
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);
    localparam bit ZR = ZERO_REG != 0;
    state_t r_state, w_state_nxt;
    logic [ADDR_W:0] r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic w_run, w_we0, w_we1, w_rsv;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= CLEAR;
            r_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt <= w_cnt_nxt;
        end
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt = r_cnt;
        if (r_state == CLEAR) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == LAST) w_state_nxt = RUN;
        end
    end
    assign w_run = r_state == RUN;
    assign ready = w_run;
    assign w_we0 = w_run && we0 && !(ZR && wa0 == ZA);
    assign w_we1 = w_run && we1 && !(ZR && wa1 == ZA);
    assign w_rsv = w_run && rsv && !(ZR && rsv_a == ZA);
    // port 1 is written last so it wins an address collision
    always_ff @(posedge clk)
        if (!w_run) r_mem[r_cnt[ADDR_W-1:0]] <= '0;
        else begin
            if (w_we0) r_mem[wa0] <= wd0;
            if (w_we1) r_mem[wa1] <= wd1;
        end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        assign w_a = ra[k*ADDR_W +: ADDR_W];
        assign rd[k*DATA_W +: DATA_W] = (!w_run || (ZR && w_a == ZA)) ? '0 :
                                        (w_we1 && wa1 == w_a) ? wd1 :
                                        (w_we0 && wa0 == w_a) ? wd0 : r_mem[w_a];
    end
    regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
        .clk(clk), .rst(rst), .i_run(w_run), .i_rsv(w_rsv), .i_rsv_a(rsv_a),
        .i_we0(w_we0), .i_wa0(wa0), .i_we1(w_we1), .i_wa1(wa1), .i_ra(ra), .o_rbusy(rbusy)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of clear sweep, bypass, write priority, scoreboard and a 4-port no-zero-reg build.
module tb_regfile_mp;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic ready, we0, we1, rsv;
    logic [9:0] ra;
    logic [63:0] rd;
    logic [1:0] rbusy;
    logic [4:0] wa0, wa1, rsv_a;
    logic [31:0] wd0, wd1;
    logic ready4, we0_4, rsv4;
    logic [19:0] ra4;
    logic [127:0] rd4;
    logic [3:0] rbusy4;
    logic [4:0] wa0_4, rsv_a4;
    logic [31:0] wd0_4;
    int n_chk = 0, n_pass = 0, cyc;
    logic [31:0] acc;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .ready(ready), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv(rsv), .rsv_a(rsv_a)
    );
    regfile_mp #(.NUM_RD(4), .ZERO_REG(0)) u_dut4 (
        .clk(clk), .rst(rst), .ready(ready4), .ra(ra4), .rd(rd4), .rbusy(rbusy4),
        .we0(we0_4), .wa0(wa0_4), .wd0(wd0_4), .we1(1'b0), .wa1(5'd0), .wd1(32'd0),
        .rsv(rsv4), .rsv_a(rsv_a4)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_ready(input string tag);
        cyc = 0;
        while (!ready && cyc < 100) begin
            step();
            cyc++;
        end
        chk(tag, 128'(cyc), 128'd32);
    endtask

    initial begin
        {we0, we1, rsv, wa0, wa1, wd0, wd1, rsv_a, ra} = '0;
        {we0_4, rsv4, wa0_4, wd0_4, rsv_a4, ra4} = '0;
        step();
        #1;
        chk("rst_ready", 128'(ready), 128'd0);
        chk("rst_rd", 128'(rd), 128'd0);
        chk("rst_rbusy", 128'(rbusy), 128'd0);
        step();
        rst = 0;
        #1;
        chk("clear_ready0", 128'(ready), 128'd0);
        wait_ready("ready_latency");
        chk("ready4", 128'(ready4), 128'd1);
        acc = '0;
        for (int a = 0; a < 32; a++) begin
            ra = {5'd0, 5'(a)};
            #1;
            acc = acc | rd[31:0];
        end
        chk("all_zero", 128'(acc), 128'd0);
        // write and same-cycle bypass
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra = {5'd0, 5'd5};
        #1 chk("bypass_wd0", 128'(rd[31:0]), 128'hDEADBEEF);
        step();
        we0 = 0; ra = {5'd5, 5'd5};
        #1 chk("stored_p0", 128'(rd[31:0]), 128'hDEADBEEF);
        chk("stored_p1", 128'(rd[63:32]), 128'hDEADBEEF);
        // write-port collision
        we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 1; wd1 = 2; ra = {5'd0, 5'd7};
        #1 chk("coll_bypass", 128'(rd[31:0]), 128'd2);
        step();
        we0 = 0; we1 = 0;
        #1 chk("coll_stored", 128'(rd[31:0]), 128'd2);
        we0 = 1; wa0 = 0; wd0 = 32'h55; ra = {5'd0, 5'd0};
        #1 chk("zero_bypass", 128'(rd[31:0]), 128'd0);
        step();
        we0 = 0;
        #1 chk("zero_stored", 128'(rd[31:0]), 128'd0);
        // scoreboard
        rsv = 1; rsv_a = 9; ra = {5'd0, 5'd9};
        #1 chk("rsv_no_bypass", 128'(rbusy[0]), 128'd0);
        step();
        rsv = 0;
        #1 chk("rsv_busy", 128'(rbusy[0]), 128'd1);
        we1 = 1; wa1 = 9; wd1 = 32'h99;
        #1 chk("wr_bypass_busy", 128'(rbusy[0]), 128'd0);
        step();
        we1 = 0;
        #1 chk("wr_cleared", 128'(rbusy[0]), 128'd0);
        rsv = 1; rsv_a = 9; we0 = 1; wa0 = 9; wd0 = 32'h77;
        #1 chk("rsv_wr_same", 128'(rbusy[0]), 128'd0);
        step();
        rsv = 0; we0 = 0;
        #1 chk("set_wins", 128'(rbusy[0]), 128'd1);
        chk("set_wins_data", 128'(rd[31:0]), 128'h77);
        rsv = 1; rsv_a = 0;
        step();
        rsv = 0; ra = {5'd0, 5'd0};
        #1 chk("rsv_zero_ign", 128'(rbusy[0]), 128'd0);
        // 4-port build without a zero register
        we0_4 = 1; wa0_4 = 0; wd0_4 = 32'h1234; ra4 = '0;
        step();
        we0_4 = 0;
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("p4_rd%0d", k), 128'(rd4[k*32 +: 32]), 128'h1234);
        rsv4 = 1; rsv_a4 = 0;
        step();
        rsv4 = 0;
        #1 chk("p4_rbusy", 128'(rbusy4), 128'hF);
        // reset mid-sweep, writes during clear ignored
        rst = 1;
        step();
        rst = 0;
        we0 = 1; wa0 = 3; wd0 = 32'hAA; ra = {5'd3, 5'd3}; rsv = 1; rsv_a = 4;
        for (int i = 0; i < 10; i++) step();
        chk("clr_rd", 128'(rd), 128'd0);
        chk("clr_rbusy", 128'(rbusy), 128'd0);
        rst = 1;
        #1 chk("mid_ready", 128'(ready), 128'd0);
        step();
        rst = 0;
        #1;
        wait_ready("ready_latency2");
        we0 = 0; rsv = 0; ra = {5'd4, 5'd3};
        #1 chk("clr_write_ign", 128'(rd[31:0]), 128'd0);
        chk("clr_rsv_ign", 128'(rbusy[1]), 128'd0);
        chk("busy_reset", 128'(rbusy[0]), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
